sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, SRAM strobe length in clocks (legal 1..15).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch read request; held until if_ready.
REQ-005 if_addr  in  16  fetch word address.
REQ-006 if_rdata  out  16  fetched word; registered, valid while if_ready=1.
REQ-007 if_ready  out  1  one-cycle fetch-complete pulse.
REQ-008 mem_req  in  1  data-stage request; held until mem_ready.
REQ-009 mem_we  in  1  1=write, 0=read.
REQ-010 mem_addr  in  16  data word address.
REQ-011 mem_wdata  in  16  write data.
REQ-012 mem_rdata  out  16  loaded word; registered, valid while mem_ready=1.
REQ-013 mem_ready  out  1  one-cycle data-complete pulse.
REQ-014 ram_addr  out  16  SRAM address.
REQ-015 ram_dout  out  16  SRAM write data.
REQ-016 ram_dout_oe  out  1  1=drive ram_dout onto SRAM bus.
REQ-017 ram_din  in  16  SRAM read data.
REQ-018 ram_ce_n, ram_oe_n, ram_we_n  out  1 each  active-low SRAM strobes.
REQ-019 stall_req  out  1  pipeline stall request to the stall controller.

Function
REQ-020 The block SHALL share the single SRAM between fetch and data stage, one access at a time.
REQ-021 States SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE; a 4-bit counter SHALL time RD and WR_PULSE.
REQ-022 Requests SHALL be sampled only in IDLE; in all other states new/changed requests are ignored.
REQ-023 IDLE with mem_req=1: mem wins regardless of if_req; latch mem_we, mem_addr, mem_wdata and the grant; go to WR_SETUP if mem_we=1, else RD.
REQ-024 IDLE with only if_req=1: latch if_addr and the grant; go to RD.
REQ-025 RD SHALL last exactly WAIT_CYCLES cycles with ram_ce_n=0, ram_oe_n=0, ram_we_n=1, ram_dout_oe=0, ram_addr=latched address.
REQ-026 On the final RD edge ram_din SHALL be captured into the granted requester's rdata register; go to DONE.
REQ-027 WR_SETUP (1 cycle): ram_ce_n=0, ram_we_n=1, ram_oe_n=1, ram_dout_oe=1, address and data driven.
REQ-028 WR_PULSE SHALL last exactly WAIT_CYCLES cycles with ram_we_n=0, address/data/ram_dout_oe unchanged.
REQ-029 WR_HOLD (1 cycle): ram_we_n=1, address, data and ram_dout_oe=1 still held; then DONE.
REQ-030 DONE (1 cycle): granted ready output =1, other ready =0, SRAM idle; then IDLE unconditionally.
REQ-031 Read latency: request sampled at edge E0 -> ready high in cycle after edge E0+WAIT_CYCLES; write: after edge E0+WAIT_CYCLES+2.
REQ-032 A requester still asserting req in the IDLE following DONE SHALL be treated as a new request.
REQ-033 In IDLE/DONE: ram_ce_n=ram_oe_n=ram_we_n=1, ram_dout_oe=0; ram_addr/ram_dout hold last value.
REQ-034 ram_we_n=0 and ram_oe_n=0 SHALL never be asserted together; ram_dout_oe=1 SHALL never coincide with ram_oe_n=0.
REQ-035 stall_req SHALL be combinational: (if_req & ~if_ready) | (mem_req & ~mem_ready).
REQ-036 rdata registers SHALL hold their value until the next capture for that requester.
REQ-037 Addresses SHALL pass through unmodified; no wrap or translation.

Reset
REQ-038 rst=0 SHALL immediately force IDLE, counter=0, if_ready=mem_ready=0, if_rdata=mem_rdata=0, ram_addr=ram_dout=0, ram_dout_oe=0, all strobes=1.
REQ-039 Reset asserted mid-access SHALL abort it without a ready pulse; ram_we_n SHALL rise asynchronously.
REQ-040 After rst rises, the first rising edge SHALL sample requests per REQ-023/024.

Verification (WAIT_CYCLES=2)
REQ-041 Fetch: if_req=1, if_addr=0x0010, ram_din=0x1234 -> oe_n low 2 cycles, if_ready pulse 1 cycle, if_rdata=0x1234.
REQ-042 Store: mem_req=1, mem_we=1, mem_addr=0x8000, mem_wdata=0xBEEF -> setup 1, we_n low 2, hold 1, mem_ready pulse; ram_dout=0xBEEF throughout.
REQ-043 Contention: if_req and mem_req (read 0x0020, ram_din=0x00AA) same edge -> mem served first (mem_rdata=0x00AA), then fetch; stall_req=1 until if_ready.
REQ-044 Back-to-back: mem_req held after mem_ready -> second access begins at next IDLE edge; exactly one IDLE cycle between accesses.
REQ-045 Reset during WR_PULSE -> we_n=1 without clock edge, no mem_ready, IDLE after release.
REQ-046 Strobe checker for whole run: REQ-034 never violated.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the fetch port, the data-stage port, the
// external SRAM pins and the stall request of sram_arbiter.
//   slave  : the arbiter's view (requests and ram_din in, everything else out)
//   master : the surrounding pipeline/SRAM view (mirror of slave)
// Signals:
//   if_req/if_addr -> if_rdata/if_ready            fetch read port
//   mem_req/mem_we/mem_addr/mem_wdata
//                  -> mem_rdata/mem_ready          data-stage read/write port
//   ram_addr/ram_dout/ram_dout_oe/ram_ce_n/ram_oe_n/ram_we_n, ram_din
//                                                  asynchronous SRAM pins
//   stall_req                                      pipeline stall request
interface sram_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ready;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic [15:0] ram_addr;
  logic [15:0] ram_dout;
  logic        ram_dout_oe;
  logic [15:0] ram_din;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  logic        stall_req;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_din,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_addr, ram_dout, ram_dout_oe, ram_ce_n, ram_oe_n, ram_we_n,
           stall_req
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_din,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_addr, ram_dout, ram_dout_oe, ram_ce_n, ram_oe_n, ram_we_n,
           stall_req
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between the fetch stage and the
// data stage, one access at a time. The data stage has fixed priority.
// Reads hold CE/OE low for WAIT_CYCLES clocks; writes use a one-cycle
// address/data setup, a WAIT_CYCLES write pulse and a one-cycle hold.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sram_arbiter_if.slave (request ports, SRAM pins, stall_req)
// Parameter:
//   WAIT_CYCLES : strobe length in clocks, 1..15
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        grant_mem;
  logic [15:0] ram_addr_q;
  logic [15:0] ram_dout_q;
  logic [15:0] if_rdata_q;
  logic [15:0] mem_rdata_q;
  logic        last_cycle;

  assign last_cycle = (cnt == LAST_CNT);

  // State register plus strobe-length counter. The counter restarts on every
  // state change, so it always counts from 0 on entry to RD / WR_PULSE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if ((state_next == state) && (state == RD || state == WR_PULSE))
        cnt <= cnt + 4'd1;
      else
        cnt <= '0;
    end
  end

  // Request latching (IDLE only) and read-data capture on the last RD edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_mem   <= 1'b0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.mem_req) begin
          grant_mem  <= 1'b1;
          ram_addr_q <= bus.mem_addr;
          ram_dout_q <= bus.mem_wdata;
        end else if (bus.if_req) begin
          grant_mem  <= 1'b0;
          ram_addr_q <= bus.if_addr;
        end
      end
      if (state == RD && last_cycle) begin
        if (grant_mem) mem_rdata_q <= bus.ram_din;
        else           if_rdata_q  <= bus.ram_din;
      end
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.mem_req)     state_next = bus.mem_we ? WR_SETUP : RD;
        else if (bus.if_req) state_next = RD;
      end
      RD:       if (last_cycle) state_next = DONE;
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: if (last_cycle) state_next = WR_HOLD;
      WR_HOLD:  state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Strobes and ready pulses decode purely from state, so reset releases the
  // SRAM (WE high) immediately without waiting for a clock edge. OE is only
  // ever low in RD, where the data driver is off and WE is high.
  always_comb begin
    bus.ram_ce_n    = 1'b1;
    bus.ram_oe_n    = 1'b1;
    bus.ram_we_n    = 1'b1;
    bus.ram_dout_oe = 1'b0;
    bus.if_ready    = 1'b0;
    bus.mem_ready   = 1'b0;
    unique case (state)
      RD: begin
        bus.ram_ce_n = 1'b0;
        bus.ram_oe_n = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        bus.ram_ce_n    = 1'b0;
        bus.ram_dout_oe = 1'b1;
      end
      WR_PULSE: begin
        bus.ram_ce_n    = 1'b0;
        bus.ram_we_n    = 1'b0;
        bus.ram_dout_oe = 1'b1;
      end
      DONE: begin
        bus.if_ready  = ~grant_mem;
        bus.mem_ready = grant_mem;
      end
      default: ;
    endcase
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  assign bus.stall_req = (bus.if_req  & ~bus.if_ready) |
                         (bus.mem_req & ~bus.mem_ready);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with WAIT_CYCLES=2.
// Expected transactions are queued as requests are driven; a negedge monitor
// pops and compares them whenever a ready pulse appears, and also checks
// strobe lengths, held address/data, strobe exclusivity and stall_req.
module tb_sram_arbiter;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [15:0] wr_mem  [256];
  bit          written [256];

  function automatic logic [15:0] preset(input logic [15:0] a);
    case (a)
      16'h0010: return 16'h1234;
      16'h0020: return 16'h00AA;
      16'h0030: return 16'h5555;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return written[a[7:0]] ? wr_mem[a[7:0]] : preset(a);
  endfunction

  always @(posedge clk) begin
    if (!bus.ram_ce_n && !bus.ram_we_n) begin
      wr_mem[bus.ram_addr[7:0]]  <= bus.ram_dout;
      written[bus.ram_addr[7:0]] <= 1'b1;
    end
  end

  always_comb begin
    bus.ram_din = 16'hDEAD;
    if (!bus.ram_ce_n && !bus.ram_oe_n) bus.ram_din = model_rd(bus.ram_addr);
  end

  // ---------------- monitor ----------------
  int   oe_cnt = 0, we_cnt = 0, sh_cnt = 0, bus_bad = 0;
  int   strobe_viol = 0, stall_bad = 0;
  txn_t mon_t;
  bit   exp_stall;

  always @(negedge clk) begin
    if (!bus.ram_we_n && !bus.ram_oe_n)   strobe_viol++;
    if (bus.ram_dout_oe && !bus.ram_oe_n) strobe_viol++;
    exp_stall = (bus.if_req && !bus.if_ready) || (bus.mem_req && !bus.mem_ready);
    if (bus.stall_req !== exp_stall) stall_bad++;

    if (!rst) begin
      oe_cnt = 0; we_cnt = 0; sh_cnt = 0; bus_bad = 0;
    end else begin
      if (!bus.ram_oe_n) oe_cnt++;
      if (!bus.ram_we_n) we_cnt++;
      if (!bus.ram_ce_n && bus.ram_we_n && bus.ram_oe_n && bus.ram_dout_oe) sh_cnt++;
      if (!bus.ram_ce_n && sb.size() != 0) begin
        if (bus.ram_addr !== sb[0].addr) bus_bad++;
        if (sb[0].we && (bus.ram_dout !== sb[0].data || !bus.ram_dout_oe)) bus_bad++;
      end
      if (bus.if_ready || bus.mem_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_t = sb.pop_front();
          check("grant_port", 32'(bus.mem_ready), 32'(mon_t.is_mem));
          if (!mon_t.we) begin
            if (mon_t.is_mem) check("mem_rdata", bus.mem_rdata, mon_t.data);
            else              check("if_rdata",  bus.if_rdata,  mon_t.data);
            check("rd_oe_len", oe_cnt, W);
          end else begin
            check("wr_pulse_len", we_cnt, W);
            check("wr_setup_hold", sh_cnt, 2);
            check("wr_no_oe", oe_cnt, 0);
            check("wr_model", model_rd(mon_t.addr), mon_t.data);
          end
          check("bus_hold", bus_bad, 0);
        end
        oe_cnt = 0; we_cnt = 0; sh_cnt = 0; bus_bad = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input string tag, input bit is_mem, input bit we,
                        input logic [15:0] addr, input logic [15:0] data,
                        input int exp_lat);
    txn_t t;
    int   n;
    bit   seen;
    t.is_mem = is_mem; t.we = we; t.addr = addr; t.data = data;
    sb.push_back(t);
    if (is_mem) begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = addr; bus.mem_wdata = data;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    @(posedge clk);  // E0: request sampled here
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (is_mem ? bus.mem_ready : bus.if_ready) seen = 1'b1;
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
    check({tag, "_lat"}, n, exp_lat);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(is_mem ? bus.mem_ready : bus.if_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   n, mem_at, if_at, gap, first_at;
    bit   if_seen;

    bus.if_req = 0; bus.if_addr = 0;
    bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_strobes", {bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n}, 3'b111);
    check("rst_dout_oe", bus.ram_dout_oe, 0);
    check("rst_ready", {bus.if_ready, bus.mem_ready}, 2'b00);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_mem_rdata", bus.mem_rdata, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_dout", bus.ram_dout, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Fetch, store, readback of the stored word
    access("fetch", 0, 0, 16'h0010, 16'h1234, W);
    access("store", 1, 1, 16'h8000, 16'hBEEF, W + 2);
    check("if_rdata_hold", bus.if_rdata, 16'h1234);
    access("readback", 0, 0, 16'h8000, 16'hBEEF, W);

    // Contention: mem read first, then fetch
    t.is_mem = 1; t.we = 0; t.addr = 16'h0020; t.data = 16'h00AA; sb.push_back(t);
    t.is_mem = 0; t.we = 0; t.addr = 16'h0070; t.data = 16'h0070 ^ 16'hA5A5; sb.push_back(t);
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 16'h0020;
    bus.if_req = 1; bus.if_addr = 16'h0070;
    @(posedge clk);
    n = 0; mem_at = 0; if_at = 0; gap = 0; if_seen = 0;
    while (!if_seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (!bus.if_ready && !bus.stall_req) gap++;
      if (bus.mem_ready) begin mem_at = n; bus.mem_req = 0; end
      if (bus.if_ready)  begin if_at = n; bus.if_req = 0; if_seen = 1; end
    end
    check("cont_mem_lat", mem_at, W);
    check("cont_if_lat", if_at, 2 * W + 2);
    check("cont_stall", gap, 0);
    @(posedge clk); #1;

    // Back-to-back: mem_req held across mem_ready
    t.is_mem = 1; t.we = 0; t.addr = 16'h0030; t.data = 16'h5555;
    sb.push_back(t); sb.push_back(t);
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 16'h0030;
    @(posedge clk);
    n = 0; first_at = 0; mem_at = 0;
    while (mem_at == 0 && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == W + 1) check("b2b_idle_ce", bus.ram_ce_n, 1);
      if (n == W + 2) check("b2b_restart_ce", bus.ram_ce_n, 0);
      if (bus.mem_ready) begin
        if (first_at == 0) first_at = n;
        else begin mem_at = n; bus.mem_req = 0; end
      end
    end
    check("b2b_first_lat", first_at, W);
    check("b2b_second_lat", mem_at, 2 * W + 2);
    @(posedge clk); #1;

    // Reset during WR_PULSE
    bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 16'h0040; bus.mem_wdata = 16'h1111;
    @(posedge clk);          // E0 -> WR_SETUP
    @(posedge clk); #1;      // WR_PULSE
    check("pre_rst_we_n", bus.ram_we_n, 0);
    #2 rst = 1'b0;
    #1;
    check("abort_we_n", bus.ram_we_n, 1);
    check("abort_ce_n", bus.ram_ce_n, 1);
    check("abort_dout_oe", bus.ram_dout_oe, 0);
    check("abort_mem_ready", bus.mem_ready, 0);
    check("abort_mem_rdata", bus.mem_rdata, 0);
    bus.mem_req = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // First edge after release samples requests
    access("post_rst", 0, 0, 16'h0050, 16'h0050 ^ 16'hA5A5, W);

    repeat (3) @(posedge clk);
    check("strobe_excl", strobe_viol, 0);
    check("stall_comb", stall_bad, 0);
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
